alu_system_control_unit: RTL and testbench

//  Hardwired FSM sequencer for ALUSystem. Drives every ALUSystem control input from its own state, IR_Out and ALU_ZCNO.

---
 rtl/alu_system_control_unit.sv | 182 ++++++++++++++++++
 tb/tb_alu_system_control_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_system_control_unit.sv
// alu_system_control_unit: hardwired sequencer for ALUSystem.
// Every instruction runs FETCH_L -> FETCH_H -> EXEC. HLT parks the unit in HALT until Reset.
// The optional macro CU_SINGLE_STEP_EN adds a Step input and a WAIT state after each EXEC.
// Handshake: none. Outputs are a pure function of state, IR_Out and ALU_ZCNO.
// They are forced to the idle vector while Reset is high.
module alu_system_control_unit #(
  parameter logic [1:0] FS_DEC  = 2'b00,
  parameter logic [1:0] FS_INC  = 2'b01,
  parameter logic [1:0] FS_LOAD = 2'b10,
  parameter logic [1:0] FS_CLR  = 2'b11
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  ALU_ZCNO,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [1:0]  SC
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [3:0] opcode;
  logic [1:0] rd, rs;
  logic [3:0] rd_oh;
  logic       unused_bits;

  assign opcode = IR_Out[15:12];
  assign rd     = IR_Out[11:10];
  assign rs     = IR_Out[9:8];
  assign rd_oh  = 4'b1000 >> rd;
  // imm8 reaches the datapath through the IR mux, not through this unit.
  assign unused_bits = ^{IR_Out[7:0], ALU_ZCNO[2:0], FS_DEC};

  // State register; asynchronous reset restarts at INIT and drops any partial fetch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Next state and Moore control vector; idle vector is the default for every path.
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutASel = 2'b00;
    ARF_OutBSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RSel    = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    Halted      = 1'b0;
    state_d     = state_q;

    case (state_q)
      S_INIT, S_FETCH_L: SC = 2'd0;
      S_FETCH_H:         SC = 2'd1;
      S_EXEC:            SC = 2'd2;
      default:           SC = 2'd3;
    endcase

    if (!Reset) begin
      case (state_q)
        S_INIT: begin
          ARF_RSel   = 4'b1110;
          ARF_FunSel = FS_CLR;
          RF_RSel    = 4'b1111;
          RF_TSel    = 4'b1111;
          RF_FunSel  = FS_CLR;
          state_d    = S_FETCH_L;
        end
        S_FETCH_L, S_FETCH_H: begin
          Mem_CS      = 1'b0;
          ARF_OutBSel = 2'b00;
          IR_Enable   = 1'b1;
          IR_LH       = (state_q == S_FETCH_H);
          IR_Funsel   = FS_LOAD;
          ARF_RSel    = 4'b1000;
          ARF_FunSel  = FS_INC;
          state_d     = (state_q == S_FETCH_L) ? S_FETCH_H : S_EXEC;
        end
        S_EXEC: begin
`ifdef CU_SINGLE_STEP_EN
          state_d = S_WAIT;
`else
          state_d = S_FETCH_L;
`endif
          case (opcode)
            4'h1: begin
              MuxASel   = 2'b10;
              RF_FunSel = FS_LOAD;
              RF_RSel   = rd_oh;
            end
            4'h2: begin
              ARF_OutBSel = 2'b01;
              Mem_CS      = 1'b0;
              MuxASel     = 2'b01;
              RF_FunSel   = FS_LOAD;
              RF_RSel     = rd_oh;
            end
            4'h3: begin
              RF_OutASel  = {1'b0, rd};
              ARF_OutBSel = 2'b01;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
              RF_OutASel = {1'b0, rd};
              RF_OutBSel = {1'b0, rs};
              case (opcode[1:0])
                2'b00:   ALU_FunSel = 4'b0100;
                2'b01:   ALU_FunSel = 4'b0110;
                2'b10:   ALU_FunSel = 4'b0111;
                default: ALU_FunSel = 4'b1000;
              endcase
              RF_FunSel = FS_LOAD;
              RF_RSel   = rd_oh;
            end
            4'h8, 4'hA: begin
              MuxBSel    = 2'b10;
              ARF_FunSel = FS_LOAD;
              ARF_RSel   = (opcode == 4'h8) ? 4'b1000 : 4'b0100;
            end
            4'h9: begin
              if (!ALU_ZCNO[3]) begin
                MuxBSel    = 2'b10;
                ARF_FunSel = FS_LOAD;
                ARF_RSel   = 4'b1000;
              end
            end
            4'hF: state_d = S_HALT;
            default: ;
          endcase
        end
        S_HALT: Halted = 1'b1;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT: if (Step) state_d = S_FETCH_L;
`endif
        default: state_d = S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_system_control_unit.sv
// tb_alu_system_control_unit: directed vectors for the ALUSystem control unit.
// Expected control vectors are written out by hand for each state/instruction.
module tb_alu_system_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IR_Out;
  logic [3:0]  ALU_ZCNO;
`ifdef CU_SINGLE_STEP_EN
  logic        Step;
`endif
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted;
  logic [1:0]  SC;

  // expected fields
  logic [2:0]  e_oa, e_ob;
  logic [1:0]  e_rfs;
  logic [3:0]  e_rs, e_ts, e_alu;
  logic [1:0]  e_aa, e_ab, e_afs;
  logic [3:0]  e_ars;
  logic        e_lh, e_ire;
  logic [1:0]  e_irf;
  logic        e_wr, e_cs;
  logic [1:0]  e_ma, e_mb;
  logic        e_mc, e_h;
  logic [1:0]  e_sc;

  logic [43:0] act_vec, exp_vec;
  int n_checks = 0;
  int n_pass   = 0;

  assign act_vec = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                    ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH, IR_Enable,
                    IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted, SC};
  assign exp_vec = {e_oa, e_ob, e_rfs, e_rs, e_ts, e_alu, e_aa, e_ab, e_afs, e_ars,
                    e_lh, e_ire, e_irf, e_wr, e_cs, e_ma, e_mb, e_mc, e_h, e_sc};

  alu_system_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_ZCNO(ALU_ZCNO),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .Halted(Halted), .SC(SC)
  );

  // clock
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic idle_exp(input logic [1:0] sc);
    e_oa = 3'b000; e_ob = 3'b000; e_rfs = 2'b00; e_rs = 4'b0000; e_ts = 4'b0000;
    e_alu = 4'b0000; e_aa = 2'b00; e_ab = 2'b00; e_afs = 2'b00; e_ars = 4'b0000;
    e_lh = 1'b0; e_ire = 1'b0; e_irf = 2'b00; e_wr = 1'b0; e_cs = 1'b1;
    e_ma = 2'b00; e_mb = 2'b00; e_mc = 1'b0; e_h = 1'b0; e_sc = sc;
  endtask

  // sample at the falling edge, then advance to just after the next rising edge
  task automatic cyc(input string tag);
    @(negedge Clock);
    check(tag, act_vec, exp_vec);
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch_l();
    idle_exp(2'd0);
    e_cs = 1'b0; e_ire = 1'b1; e_irf = 2'b10; e_ars = 4'b1000; e_afs = 2'b01;
    cyc("fetch_l");
  endtask

  task automatic fetch_h();
    idle_exp(2'd1);
    e_cs = 1'b0; e_ire = 1'b1; e_lh = 1'b1; e_irf = 2'b10; e_ars = 4'b1000; e_afs = 2'b01;
    cyc("fetch_h");
  endtask

  task automatic init_exp();
    idle_exp(2'd0);
    e_ars = 4'b1110; e_afs = 2'b11; e_rs = 4'b1111; e_ts = 4'b1111; e_rfs = 2'b11;
  endtask

  // between EXEC and the next FETCH_L when single-stepping
  task automatic after_exec(input int hold);
`ifdef CU_SINGLE_STEP_EN
    idle_exp(2'd3);
    for (int i = 0; i < hold; i++) cyc("wait_hold");
    Step = 1'b1;
    cyc("wait_step");
    Step = 1'b0;
`else
    if (hold < 0) $display("hold %0d", hold);
`endif
  endtask

  task automatic exec_prep(input logic [15:0] ir, input logic [3:0] zcno);
    IR_Out = ir; ALU_ZCNO = zcno;
    idle_exp(2'd2);
  endtask

  initial begin
    Reset = 1'b1; IR_Out = 16'h0000; ALU_ZCNO = 4'b0000;
`ifdef CU_SINGLE_STEP_EN
    Step = 1'b0;
`endif
    @(posedge Clock); #1;
    idle_exp(2'd0);
    cyc("reset_idle");
    Reset = 1'b0;
    init_exp();
    cyc("init");

    // LDI R1,0x2A
    fetch_l(); fetch_h();
    exec_prep(16'h102A, 4'b0000); e_ma = 2'b10; e_rfs = 2'b10; e_rs = 4'b1000;
    cyc("ldi_r1");
    after_exec(10);

    // LDI R2,0x05
    fetch_l(); fetch_h();
    exec_prep(16'h1405, 4'b0000); e_ma = 2'b10; e_rfs = 2'b10; e_rs = 4'b0100;
    cyc("ldi_r2");
    after_exec(1);

    // ADD R1,R2
    fetch_l(); fetch_h();
    exec_prep(16'h4100, 4'b0000); e_ob = 3'b001; e_alu = 4'b0100; e_rfs = 2'b10; e_rs = 4'b1000;
    cyc("add");
    after_exec(1);

    // SUB R1,R1
    fetch_l(); fetch_h();
    exec_prep(16'h5000, 4'b0000); e_alu = 4'b0110; e_rfs = 2'b10; e_rs = 4'b1000;
    cyc("sub");
    after_exec(1);

    // BNE 0x20 with Z=1 -> not taken
    fetch_l(); fetch_h();
    exec_prep(16'h9020, 4'b1000);
    cyc("bne_nt");
    after_exec(1);

    // BNE 0x20 with Z=0 -> taken
    fetch_l(); fetch_h();
    exec_prep(16'h9020, 4'b0000); e_mb = 2'b10; e_ars = 4'b1000; e_afs = 2'b10;
    cyc("bne_t");
    after_exec(1);

    // BRA 0x10
    fetch_l(); fetch_h();
    exec_prep(16'h8010, 4'b1000); e_mb = 2'b10; e_ars = 4'b1000; e_afs = 2'b10;
    cyc("bra");
    after_exec(1);

    // LDAR 0x40
    fetch_l(); fetch_h();
    exec_prep(16'hA040, 4'b0000); e_mb = 2'b10; e_ars = 4'b0100; e_afs = 2'b10;
    cyc("ldar");
    after_exec(1);

    // ST R2
    fetch_l(); fetch_h();
    exec_prep(16'h3400, 4'b0000); e_oa = 3'b001; e_ab = 2'b01; e_cs = 1'b0; e_wr = 1'b1;
    cyc("st");
    after_exec(1);

    // LD R3
    fetch_l(); fetch_h();
    exec_prep(16'h2800, 4'b0000); e_ab = 2'b01; e_cs = 1'b0; e_ma = 2'b01; e_rfs = 2'b10; e_rs = 4'b0010;
    cyc("ld");
    after_exec(1);

    // AND R3,R4 and OR R4,R1
    fetch_l(); fetch_h();
    exec_prep(16'h6B00, 4'b0000); e_oa = 3'b010; e_ob = 3'b011; e_alu = 4'b0111; e_rfs = 2'b10; e_rs = 4'b0010;
    cyc("and");
    after_exec(1);
    fetch_l(); fetch_h();
    exec_prep(16'h7C00, 4'b0000); e_oa = 3'b011; e_ob = 3'b000; e_alu = 4'b1000; e_rfs = 2'b10; e_rs = 4'b0001;
    cyc("or");
    after_exec(1);

    // undefined opcode behaves as NOP
    fetch_l(); fetch_h();
    exec_prep(16'hC5FF, 4'b0000);
    cyc("nop");
    after_exec(1);

    // reset during FETCH_H: idle at once, INIT after release
    fetch_l();
    Reset = 1'b1;
    idle_exp(2'd0);
    cyc("rst_mid_fetch");
    Reset = 1'b0;
    init_exp();
    cyc("init_after_rst");

    // HLT then stay halted
    fetch_l(); fetch_h();
    exec_prep(16'hF000, 4'b0000);
    cyc("hlt_exec");
    idle_exp(2'd3); e_h = 1'b1;
    for (int i = 0; i < 20; i++) cyc("halted");

    // reset leaves HALT
    Reset = 1'b1;
    idle_exp(2'd0);
    cyc("rst_from_halt");
    Reset = 1'b0;
    init_exp();
    cyc("init_from_halt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
